// File: rtl/jingle_pkg.sv
// jingle_pkg
// Shared types and defaults for the jingle sequencer.
//   state_t        : sequencer FSM state encoding (IDLE, NOTE, GAP)
//   DEF_*          : default beat length, gap length and final step index
//   BCD_MAX        : largest value a BCD digit may hold
//   to_bcd8()      : converts a decimal step number 0..99 to two packed BCD digits
package jingle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_BEAT_CYCLES = 25_000_000;
    localparam int DEF_GAP_CYCLES  = 2_500_000;
    localparam int DEF_LAST_STEP   = 12;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [7:0] to_bcd8(input int value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'((value / 10) % 10);
        ones = 4'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_step_counter.sv
// bcd_step_counter
// Two-digit BCD step register (tens:ones) used as the jingle note index.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear to 00 (wins over inc)
//   inc       : advance one step in BCD; ignored once the index equals last
//   last[7:0] : final step, packed BCD {tens, ones}
//   ones,tens : current index digits (registered)
//   at_last   : current index equals last
module bcd_step_counter
    import jingle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] last,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       at_last
);

    assign at_last = ({tens, ones} == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (clr) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (inc && !at_last) begin
            if (ones == BCD_MAX) begin
                ones <= 4'd0;
                // The tens digit wraps rather than leaving BCD range; with
                // last <= 99 the at_last guard keeps this from ever happening.
                tens <= (tens == BCD_MAX) ? 4'd0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/jingle_sequencer.sv
// jingle_sequencer
// Steps a two-digit BCD note index at a programmable beat rate, with an
// optional muted gap after every note so repeated notes stay distinct.
// Parameters:
//   BEAT_CYCLES : clock cycles each note sounds (>= 2)
//   GAP_CYCLES  : muted cycles after each note (0 = no gap)
//   LAST_STEP   : final note index, decimal 0..99
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : one-cycle request to play from step 00 (ignored while busy)
//   stop        : abort request, highest priority
//   num0, num1  : BCD ones / tens digit of the current step
//   mute        : speaker must be silent
//   busy        : jingle in progress (NOTE or GAP)
//   done        : one-cycle pulse on normal completion, aligned with busy falling
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not playing; index 00, muted
// NOTE  | current index sounding, beat counter running
// GAP   | muted separation after a note, index held, gap counter running
module jingle_sequencer
    import jingle_pkg::*;
#(
    parameter int BEAT_CYCLES = DEF_BEAT_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int LAST_STEP   = DEF_LAST_STEP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] num0,
    output logic [3:0] num1,
    output logic       mute,
    output logic       busy,
    output logic       done
);

    localparam int BEAT_W = $clog2(BEAT_CYCLES);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam bit                HAS_GAP   = (GAP_CYCLES > 0);
    localparam logic [7:0]        LAST_BCD  = to_bcd8(LAST_STEP);

    state_t state, state_d;

    logic [BEAT_W-1:0] beat_cnt, beat_cnt_d;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;

    logic step_clr;
    logic step_inc;
    logic at_last;
    logic done_d;

    bcd_step_counter u_step (
        .clk     (clk),
        .rst     (rst),
        .clr     (step_clr),
        .inc     (step_inc),
        .last    (LAST_BCD),
        .ones    (num0),
        .tens    (num1),
        .at_last (at_last)
    );

    // Counters default to zero so any state change (or a note-to-note
    // step with no gap) leaves them cleared for the next state.
    always_comb begin
        state_d    = state;
        beat_cnt_d = '0;
        gap_cnt_d  = '0;
        step_clr   = 1'b0;
        step_inc   = 1'b0;
        done_d     = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = NOTE;
                    step_clr = 1'b1;
                end
            end

            NOTE: begin
                if (stop) begin
                    state_d  = IDLE;
                    step_clr = 1'b1;
                end else if (beat_cnt == BEAT_LAST) begin
                    if (HAS_GAP) begin
                        state_d = GAP;
                    end else if (at_last) begin
                        state_d  = IDLE;
                        step_clr = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        step_inc = 1'b1;
                    end
                end else begin
                    beat_cnt_d = beat_cnt + 1'b1;
                end
            end

            GAP: begin
                if (stop) begin
                    state_d  = IDLE;
                    step_clr = 1'b1;
                end else if (gap_cnt == GAP_LAST) begin
                    if (at_last) begin
                        state_d  = IDLE;
                        step_clr = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        // Index advances on the same edge mute drops.
                        state_d  = NOTE;
                        step_inc = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_d  = IDLE;
                step_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            mute     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            beat_cnt <= beat_cnt_d;
            gap_cnt  <= gap_cnt_d;
            mute     <= (state_d != NOTE);
            busy     <= (state_d != IDLE);
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_jingle_sequencer.sv
module tb_jingle_sequencer;

    localparam int BEAT_A = 4;
    localparam int GAP_A  = 1;
    localparam int LAST_A = 12;
    localparam int BEAT_B = 4;
    localparam int GAP_B  = 0;
    localparam int LAST_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;

    logic [3:0] num0_a, num1_a, num0_b, num1_b;
    logic       mute_a, busy_a, done_a, mute_b, busy_b, done_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jingle_sequencer #(.BEAT_CYCLES(BEAT_A), .GAP_CYCLES(GAP_A), .LAST_STEP(LAST_A)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .num0(num0_a), .num1(num1_a), .mute(mute_a), .busy(busy_a), .done(done_a)
    );

    jingle_sequencer #(.BEAT_CYCLES(BEAT_B), .GAP_CYCLES(GAP_B), .LAST_STEP(LAST_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .num0(num0_b), .num1(num1_b), .mute(mute_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: elapsed time since the first busy cycle determines
    // everything (step = t / period, muted when t mod period >= beat).
    bit act[2];
    bit dn[2];
    int t[2];

    function automatic int beat_of(input int m);
        return (m == 0) ? BEAT_A : BEAT_B;
    endfunction

    function automatic int gap_of(input int m);
        return (m == 0) ? GAP_A : GAP_B;
    endfunction

    function automatic int total_of(input int m);
        int last;
        last = (m == 0) ? LAST_A : LAST_B;
        return (last + 1) * (beat_of(m) + gap_of(m));
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                act[m] <= 1'b0;
                dn[m]  <= 1'b0;
                t[m]   <= 0;
            end else if (stop) begin
                act[m] <= 1'b0;
                dn[m]  <= 1'b0;
                t[m]   <= 0;
            end else if (act[m]) begin
                t[m]   <= t[m] + 1;
                act[m] <= (t[m] + 1 != total_of(m));
                dn[m]  <= (t[m] + 1 == total_of(m));
            end else begin
                dn[m] <= 1'b0;
                if (start) begin
                    act[m] <= 1'b1;
                    t[m]   <= 0;
                end
            end
        end
    end

    function automatic logic [10:0] exp_vec(input int m);
        int per;
        int step;
        int ph;
        logic [7:0] idx;
        if (!act[m]) return {8'h00, 1'b1, 1'b0, dn[m]};
        per  = beat_of(m) + gap_of(m);
        step = t[m] / per;
        ph   = t[m] % per;
        idx  = {4'(step / 10), 4'(step % 10)};
        return {idx, (ph >= beat_of(m)), 1'b1, dn[m]};
    endfunction

    always @(negedge clk) begin
        chk("cyc_a", 32'({num1_a, num0_a, mute_a, busy_a, done_a}), 32'(exp_vec(0)));
        chk("cyc_b", 32'({num1_b, num0_b, mute_b, busy_b, done_b}), 32'(exp_vec(1)));
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idx_a(input logic [7:0] target, output bit ok);
        int n;
        n = 0;
        while ({num1_a, num0_a} !== target && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 300);
    endtask

    initial begin
        int n, nb, dcnt, hold;
        bit saw, bad, ok, inj;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done_a || done_b) saw = 1'b1;
        end
        chk("idle_done", 32'(saw), 32'd0);
        chk("idle_out", 32'({num1_a, num0_a, mute_a, busy_a}), 32'({8'h00, 1'b1, 1'b0}));

        // full run on both instances
        @(negedge clk);
        pulse_start();
        chk("start_vis", 32'({num1_a, num0_a, mute_a, busy_a}), 32'({8'h00, 1'b0, 1'b1}));
        n = 0; nb = 0; bad = 1'b0;
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
            if (done_b && nb == 0) nb = n;
            if (busy_b && mute_b) bad = 1'b1;
        end
        chk("len_a", 32'(n), 32'd65);
        chk("len_b", 32'(nb), 32'd16);
        chk("gap0_mute", 32'(bad), 32'd0);
        chk("busy_fall", 32'(busy_a), 32'd0);
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_a) dcnt++;
        end
        chk("done_once", 32'(dcnt), 32'd0);

        // stop during step 05
        pulse_start();
        wait_idx_a(8'h05, ok);
        chk("wait05", 32'(ok), 32'd1);
        stop = 1'b1;
        @(negedge clk);
        chk("stop_idle", 32'({num1_a, num0_a, mute_a, busy_a, done_a}), 32'({8'h00, 1'b1, 1'b0, 1'b0}));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_w_stop", 32'(busy_a), 32'd0);
        @(negedge clk);
        chk("start_w_stop2", 32'(busy_a), 32'd0);
        stop = 1'b0;
        repeat (3) @(negedge clk);

        // restart attempt during step 07
        pulse_start();
        n = 0; inj = 1'b0;
        while (!done_a && n < 200) begin
            if ({num1_a, num0_a} == 8'h07 && !inj) begin
                start = 1'b1;
                inj = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("restart_inj", 32'(inj), 32'd1);
        chk("restart_len", 32'(n), 32'd65);
        repeat (3) @(negedge clk);

        // asynchronous reset mid-GAP
        pulse_start();
        n = 0;
        while (!(busy_a && mute_a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_gap", 32'(n < 50), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_a", 32'({num1_a, num0_a, mute_a, busy_a, done_a}), 32'({8'h00, 1'b1, 1'b0, 1'b0}));
        chk("async_rst_b", 32'({num1_b, num0_b, mute_b, busy_b, done_b}), 32'({8'h00, 1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        chk("replay", 32'({num1_a, num0_a, mute_a, busy_a}), 32'({8'h00, 1'b0, 1'b1}));
        n = 0;
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("replay_len", 32'(n), 32'd65);

        // randomized starts and stops, checked cycle by cycle
        hold = 0;
        repeat (3000) begin
            start = ($urandom_range(0, 15) == 0);
            if (hold > 0) begin
                hold--;
                stop = (hold > 0);
            end else if ($urandom_range(0, 149) == 0) begin
                hold = $urandom_range(1, 3);
                stop = 1'b1;
            end else begin
                stop = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        stop = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
